// File: rtl/fifo_uart_tx_if.sv
// FIFO-side bundle for the UART drain stage: empty/data in, read strobe and serial line out.
// Latency: pure wiring, none.
// Backpressure: none here; the drain stage paces itself off empty and its own frame timer.
interface fifo_uart_tx_if;
   logic       en;
   logic       empty;
   logic [7:0] fifo_data;
   logic       rd;
   logic       tx;
   logic       busy;
   logic       frame_done;

   // master: the drain stage, which owns the read strobe and the serial line
   modport master (
      input  en,
      input  empty,
      input  fifo_data,
      output rd,
      output tx,
      output busy,
      output frame_done
   );

   // slave: the FIFO / controller side that feeds the drain stage
   modport slave (
      output en,
      output empty,
      output fifo_data,
      input  rd,
      input  tx,
      input  busy,
      input  frame_done
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from an upstream FIFO and shifts each out as an 8N1 (optionally parity) UART frame.
// Latency: rd one cycle after empty=0 seen in IDLE; start bit two cycles after rd; frame (10+PARITY_EN)*CLKS_PER_BIT.
// Backpressure: only reads while en=1 and empty=0 in IDLE; a started frame always completes.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 10,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic           clock,
   input  logic           rst,
   fifo_uart_tx_if.master bus
);

   // Baud counter is just wide enough to count 0..CLKS_PER_BIT-1.
   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_LOAD,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t        r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_par;
   logic          r_rd;
   logic          r_tx;
   logic          r_busy;
   logic          r_fd;

   logic          w_bit_end;

   assign w_bit_end = (r_baud == BAUD_LAST);

   // Frame sequencer: all outputs are registered and set on the transition into the state that owns them.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_rd    <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_fd    <= 1'b0;
      end else begin
         r_fd <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (bus.en && !bus.empty) begin
                  r_state <= S_REQ;
                  r_rd    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_baud  <= '0;
               end
            end
            // Single-cycle read strobe; empty is deliberately not re-checked here.
            S_REQ: begin
               r_rd    <= 1'b0;
               r_baud  <= '0;
               r_state <= S_LOAD;
            end
            // FIFO data is valid now; parity is precomputed so the parity bit needs no extra logic later.
            S_LOAD: begin
               r_shift <= bus.fifo_data;
               r_par   <= (^bus.fifo_data) ^ PARITY_ODD;
               r_tx    <= 1'b0;
               r_baud  <= '0;
               r_state <= S_START;
            end
            S_START: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            // LSB first: tx always shows shift[0]; the next bit is shift[1] before the shift lands.
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     if (PARITY_EN) begin
                        r_tx    <= r_par;
                        r_state <= S_PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            // frame_done is raised one cycle early so the registered pulse lands on the last stop cycle.
            S_STOP: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_baud <= r_baud + 1'b1;
                  if (r_baud == BAUD_PRE) begin
                     r_fd <= 1'b1;
                  end
               end
            end
            default: begin
               r_rd    <= 1'b0;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rd         = r_rd;
   assign bus.tx         = r_tx;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_fd;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three lanes (no parity, even parity, odd parity) each fed by a FIFO model.
// Stimulus pushes hand-computed expected frames into per-lane queues; a monitor decodes tx and pops/compares.
// Counters n_vec / n_err feed the single summary line.
module tb_fifo_uart_tx;
   localparam int CPB = 4;

   logic clock = 1'b0;
   logic rst;
   always #5 clock = ~clock;

   fifo_uart_tx_if if0 ();
   fifo_uart_tx_if if1 ();
   fifo_uart_tx_if if2 ();

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
      dut0 (.clock(clock), .rst(rst), .bus(if0));
   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
      dut1 (.clock(clock), .rst(rst), .bus(if1));
   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
      dut2 (.clock(clock), .rst(rst), .bus(if2));

   logic       en_r    [3];
   logic [7:0] fdat_r  [3];
   logic       empty_w [3];
   logic       rd_w    [3];
   logic       tx_w    [3];
   logic       busy_w  [3];
   logic       fd_w    [3];

   assign if0.en = en_r[0];  assign if0.empty = empty_w[0];  assign if0.fifo_data = fdat_r[0];
   assign if1.en = en_r[1];  assign if1.empty = empty_w[1];  assign if1.fifo_data = fdat_r[1];
   assign if2.en = en_r[2];  assign if2.empty = empty_w[2];  assign if2.fifo_data = fdat_r[2];
   assign rd_w[0] = if0.rd;  assign tx_w[0] = if0.tx;  assign busy_w[0] = if0.busy;  assign fd_w[0] = if0.frame_done;
   assign rd_w[1] = if1.rd;  assign tx_w[1] = if1.tx;  assign busy_w[1] = if1.busy;  assign fd_w[1] = if1.frame_done;
   assign rd_w[2] = if2.rd;  assign tx_w[2] = if2.tx;  assign busy_w[2] = if2.busy;  assign fd_w[2] = if2.frame_done;

   // FIFO model: storage written by stimulus, read pointer advanced when rd is sampled.
   logic [7:0] fmem [0:2][0:7];
   int         fwr  [3];
   int         frd  [3];

   for (genvar i = 0; i < 3; i++) begin : g_empty
      assign empty_w[i] = (frd[i] == fwr[i]);
   end

   always @(posedge clock) begin
      for (int l = 0; l < 3; l++) begin
         if (!rst && rd_w[l] && (frd[l] != fwr[l])) begin
            fdat_r[l] <= fmem[l][frd[l]];
            frd[l]    <= frd[l] + 1;
         end
      end
   end

   // Expected-frame queues: bit i of a frame is the i-th serial bit on the line.
   logic [10:0] exp_frm [0:2][0:15];
   int          exp_nb  [0:2][0:15];
   int          exp_wr  [3];
   int          exp_rd  [3];

   int n_vec;
   int n_err;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Monitor state
   bit          mon_on;
   int          cyc;
   bit          in_frame [3];
   int          fpos     [3];
   logic [10:0] obs      [3];
   logic [10:0] cur_exp  [3];
   int          cur_nb   [3];
   int          fd_pos   [3];
   int          rd_cnt   [3];
   int          fd_cnt   [3];
   int          rd_last  [3];
   int          rd_gap   [3];
   bit          rd_prev  [3];

   initial begin
      for (int l = 0; l < 3; l++) rd_last[l] = -1000;
      forever begin
         @(negedge clock);
         cyc++;
         if (rst || !mon_on) begin
            for (int l = 0; l < 3; l++) begin
               in_frame[l] = 1'b0;
               rd_prev[l]  = 1'b0;
            end
         end else begin
            for (int l = 0; l < 3; l++) begin
               if (rd_w[l]) begin
                  check("rd_single_cycle", rd_prev[l], 0);
                  check("rd_vs_frame_done", fd_w[l], 0);
                  rd_cnt[l]++;
                  rd_gap[l]  = cyc - rd_last[l];
                  rd_last[l] = cyc;
               end
               rd_prev[l] = rd_w[l];
               if (fd_w[l]) fd_cnt[l]++;
               if (!in_frame[l]) begin
                  if (tx_w[l] == 1'b0) begin
                     in_frame[l] = 1'b1;
                     fpos[l]     = 0;
                     obs[l]      = '0;
                     fd_pos[l]   = -1;
                     check("rd_to_start", cyc - rd_last[l], 2);
                     check("busy_at_start", busy_w[l], 1);
                     check("frame_expected", (exp_wr[l] != exp_rd[l]), 1);
                     if (exp_wr[l] != exp_rd[l]) begin
                        cur_exp[l] = exp_frm[l][exp_rd[l]];
                        cur_nb[l]  = exp_nb[l][exp_rd[l]];
                        exp_rd[l]++;
                     end else begin
                        cur_exp[l] = '0;
                        cur_nb[l]  = 10;
                     end
                  end
               end else begin
                  fpos[l]++;
               end
               if (in_frame[l]) begin
                  if ((fpos[l] % CPB) == (CPB / 2)) obs[l][fpos[l] / CPB] = tx_w[l];
                  if (fd_w[l]) fd_pos[l] = fpos[l];
                  if (fpos[l] == cur_nb[l] * CPB) begin
                     check("frame_bits", obs[l], cur_exp[l]);
                     check("frame_done_pos", fd_pos[l], cur_nb[l] * CPB - 1);
                     check("busy_after_frame", busy_w[l], 0);
                     check("tx_idle_after_frame", tx_w[l], 1);
                     in_frame[l] = 1'b0;
                  end
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic push_byte(input int l, input logic [7:0] b);
      fmem[l][fwr[l]] = b;
      fwr[l]++;
   endtask

   task automatic push_exp(input int l, input logic [10:0] f, input int nb);
      exp_frm[l][exp_wr[l]] = f;
      exp_nb[l][exp_wr[l]]  = nb;
      exp_wr[l]++;
   endtask

   task automatic wait_idle(input int l, input int budget, input string nm);
      int k;
      k = 0;
      while (!((exp_rd[l] == exp_wr[l]) && !in_frame[l]) && (k < budget)) begin
         tick(1);
         k++;
      end
      check(nm, (k < budget), 1);
   endtask

   task automatic wait_pos(input int l, input int pos, input int budget, input string nm);
      int k;
      k = 0;
      while (!(in_frame[l] && (fpos[l] == pos)) && (k < budget)) begin
         tick(1);
         k++;
      end
      check(nm, (k < budget), 1);
   endtask

   initial begin
      rst = 1'b0;
      for (int l = 0; l < 3; l++) en_r[l] = 1'b0;

      // Reset pulsed between edges with every FIFO empty.
      @(negedge clock);
      #1;
      rst = 1'b1;
      #1;
      for (int l = 0; l < 3; l++) begin
         check("rst_tx", tx_w[l], 1);
         check("rst_rd", rd_w[l], 0);
         check("rst_busy", busy_w[l], 0);
         check("rst_frame_done", fd_w[l], 0);
      end
      tick(2);
      rst    = 1'b0;
      mon_on = 1'b1;
      for (int l = 0; l < 3; l++) en_r[l] = 1'b1;
      tick(100);
      for (int l = 0; l < 3; l++) check("no_rd_when_empty", rd_cnt[l], 0);

      // Single byte 0xA5: serial 0,1,0,1,0,0,1,0,1,1
      push_exp(0, 11'h34A, 10);
      push_byte(0, 8'hA5);
      wait_idle(0, 200, "wait_a5");
      check("a5_rd_count", rd_cnt[0], 1);
      check("a5_fd_count", fd_cnt[0], 1);

      // Back-to-back 0x00 then 0xFF
      push_exp(0, 11'h200, 10);
      push_exp(0, 11'h3FE, 10);
      push_byte(0, 8'h00);
      push_byte(0, 8'hFF);
      wait_idle(0, 300, "wait_b2b");
      check("b2b_rd_count", rd_cnt[0], 3);
      check("b2b_rd_gap", rd_gap[0], 43);
      check("b2b_fifo_empty", empty_w[0], 1);
      check("b2b_fd_count", fd_cnt[0], 3);

      // Parity on 0x07: even -> parity bit 1, odd -> parity bit 0
      push_exp(1, 11'h60E, 11);
      push_byte(1, 8'h07);
      push_exp(2, 11'h40E, 11);
      push_byte(2, 8'h07);
      wait_idle(1, 200, "wait_par_even");
      wait_idle(2, 200, "wait_par_odd");
      check("par_even_rd_count", rd_cnt[1], 1);
      check("par_odd_rd_count", rd_cnt[2], 1);
      check("par_even_fd_count", fd_cnt[1], 1);
      check("par_odd_fd_count", fd_cnt[2], 1);

      // en gating: nothing starts with en=0; a frame in progress survives en dropping.
      en_r[0] = 1'b0;
      push_exp(0, 11'h2B4, 10);
      push_byte(0, 8'h5A);
      push_byte(0, 8'h3C);
      tick(50);
      check("en_low_no_rd", rd_cnt[0], 3);
      en_r[0] = 1'b1;
      wait_pos(0, 10, 30, "wait_en_frame_start");
      en_r[0] = 1'b0;
      wait_idle(0, 200, "wait_en_frame_end");
      tick(100);
      check("en_mid_no_new_rd", rd_cnt[0], 4);
      check("en_mid_fd_count", fd_cnt[0], 4);
      check("en_fifo_still_holds", empty_w[0], 0);

      // Reset during data bit 3 of 0x3C (serial bit 4); this frame is expected to be cut short.
      push_exp(0, 11'h278, 10);
      en_r[0] = 1'b1;
      wait_pos(0, 17, 40, "wait_data_bit3");
      check("pre_rst_busy", busy_w[0], 1);
      check("pre_rst_tx_bit3", tx_w[0], 1);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", tx_w[0], 1);
      check("mid_rst_rd", rd_w[0], 0);
      check("mid_rst_busy", busy_w[0], 0);
      check("mid_rst_frame_done", fd_w[0], 0);
      tick(2);
      rst = 1'b0;
      tick(100);
      check("post_rst_rd_count", rd_cnt[0], 5);
      check("post_rst_fd_count", fd_cnt[0], 4);
      check("post_rst_fifo_empty", empty_w[0], 1);
      check("post_rst_tx_idle", tx_w[0], 1);

      for (int l = 0; l < 3; l++) check("exp_queue_drained", exp_wr[l] - exp_rd[l], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied, %0d miscompares", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
